// File: rtl/ibex_pkg.sv
// Shared types and constants for the register-file writeback path.
package ibex_pkg;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned RfWbDataW = 32;

    // One pending-load slot: live clears when a younger write to the same
    // register overtakes the load, so the stale value is never written.
    typedef struct packed {
        logic                 live;
        logic [RegAddrW-1:0]  addr;
        logic [RfWbDataW-1:0] data;
    } rf_wb_entry_t;

    // x0 is hardwired zero: it is never parked, killed or forwarded.
    function automatic logic is_real_reg(input logic [RegAddrW-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Pending-load FIFO: in-order storage, WAW kill matching and youngest-match
// forwarding search for the two register file read ports.
module ibex_rf_wb_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2,
    localparam int unsigned CntW     = $clog2(Depth + 1),
    localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push,
    input  logic [4:0]           push_addr,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    input  logic                 kill_en,
    input  logic [4:0]           kill_addr,
    input  logic [4:0]           raddr_a,
    input  logic [4:0]           raddr_b,
    output logic                 head_live,
    output logic [4:0]           head_addr,
    output logic [DataWidth-1:0] head_data,
    output logic [CntW-1:0]      count,
    output logic                 fwd_a_hit,
    output logic [DataWidth-1:0] fwd_a_data,
    output logic                 fwd_b_hit,
    output logic [DataWidth-1:0] fwd_b_data
);

    logic                 live_q [Depth];
    logic [4:0]           addr_q [Depth];
    logic [DataWidth-1:0] data_q [Depth];
    logic [PtrW-1:0]      head_q;
    logic [PtrW-1:0]      tail_q;
    logic [CntW-1:0]      count_q;
    logic [Depth-1:0]     kill_vec;
    logic [PtrW-1:0]      slot;

    // Pointer advance modulo Depth (Depth need not be a power of two).
    function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= Depth) s = s - Depth;
        return s[PtrW-1:0];
    endfunction

    assign head_live = live_q[head_q];
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;

    // Kill-match vector: live entries overtaken by a younger execute write.
    always_comb begin
        kill_vec = '0;
        for (int i = 0; i < Depth; i++) begin
            kill_vec[i] = kill_en && is_real_reg(kill_addr) && live_q[i] &&
                          (addr_q[i] == kill_addr);
        end
    end

    // Forwarding: walk oldest to youngest so the entry nearest the tail wins.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        slot       = '0;
        for (int k = 0; k < Depth; k++) begin
            slot = ptr_add(head_q, k);
            if ((k < int'(count_q)) && live_q[slot]) begin
                if (is_real_reg(raddr_a) && (addr_q[slot] == raddr_a)) begin
                    fwd_a_hit  = 1'b1;
                    fwd_a_data = data_q[slot];
                end
                if (is_real_reg(raddr_b) && (addr_q[slot] == raddr_b)) begin
                    fwd_b_hit  = 1'b1;
                    fwd_b_data = data_q[slot];
                end
            end
        end
    end

    // Storage, pointers and occupancy; a popped slot leaves even if killed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                live_q[i] <= 1'b0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (kill_vec[i]) live_q[i] <= 1'b0;
            end
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= ptr_add(head_q, 1);
            end
            if (push) begin
                live_q[tail_q] <= 1'b1;
                addr_q[tail_q] <= push_addr;
                data_q[tail_q] <= push_data;
                tail_q         <= ptr_add(tail_q, 1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Writeback arbiter in front of the register file's single write port:
// execute results win, parked loads drain when execute is idle, and a load
// arriving to an empty queue on an idle cycle bypasses straight through.
module ibex_rf_wb_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ex_we_i,
    input  logic [4:0]                   ex_waddr_i,
    input  logic [DataWidth-1:0]         ex_wdata_i,
    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic [4:0]                   lsu_waddr_i,
    input  logic [DataWidth-1:0]         lsu_wdata_i,
    output logic                         rf_we_o,
    output logic [4:0]                   rf_waddr_o,
    output logic [DataWidth-1:0]         rf_wdata_o,
    input  logic [4:0]                   raddr_a_i,
    input  logic [4:0]                   raddr_b_i,
    output logic                         fwd_a_hit_o,
    output logic                         fwd_b_hit_o,
    output logic [DataWidth-1:0]         fwd_a_data_o,
    output logic [DataWidth-1:0]         fwd_b_data_o,
    output logic [$clog2(Depth+1)-1:0]   pending_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    // Load handshake: a transfer happens on a clock edge where lsu_valid_i
    // and lsu_ready_o are both high. Ready is a function of registered
    // occupancy only (no combinational path from a same-cycle pop), and once
    // the transfer happens the load is owned here even if it is then dropped.
    logic                 lsu_acc;
    logic                 fifo_empty;
    logic                 pop;
    logic                 bypass;
    logic                 push;
    logic                 same_dst;
    logic                 head_live;
    logic [4:0]           head_addr;
    logic [DataWidth-1:0] head_data;
    logic [CntW-1:0]      count;

    assign lsu_ready_o = (count < CntW'(Depth));
    assign lsu_acc     = lsu_valid_i && lsu_ready_o;
    assign fifo_empty  = (count == '0);
    assign pending_o   = count;
    assign same_dst    = ex_we_i && (lsu_waddr_i == ex_waddr_i);

    // Write-port priority: execute, then queue head, then bypassed load.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        pop        = 1'b0;
        bypass     = 1'b0;
        if (ex_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            rf_we_o    = head_live;
            rf_waddr_o = head_addr;
            rf_wdata_o = head_data;
        end else if (lsu_acc) begin
            bypass     = 1'b1;
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end
    end

    // Park accepted loads that were not bypassed; a load colliding with a
    // same-cycle execute write to the same register is already stale.
    always_comb begin
        push = lsu_acc && !bypass && !same_dst && is_real_reg(lsu_waddr_i);
    end

    ibex_rf_wb_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (push),
        .push_addr  (lsu_waddr_i),
        .push_data  (lsu_wdata_i),
        .pop        (pop),
        .kill_en    (ex_we_i),
        .kill_addr  (ex_waddr_i),
        .raddr_a    (raddr_a_i),
        .raddr_b    (raddr_b_i),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .fwd_a_hit  (fwd_a_hit_o),
        .fwd_a_data (fwd_a_data_o),
        .fwd_b_hit  (fwd_b_hit_o),
        .fwd_b_data (fwd_b_data_o)
    );

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for the writeback arbiter: register-file writes are
// scoreboarded against an expected queue, state outputs checked in place.
module tb_ibex_rf_wb_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_we;
    logic [4:0]    ex_waddr;
    logic [DW-1:0] ex_wdata;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_waddr;
    logic [DW-1:0] lsu_wdata;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [4:0]    raddr_a;
    logic [4:0]    raddr_b;
    logic          fwd_a_hit;
    logic          fwd_b_hit;
    logic [DW-1:0] fwd_a_data;
    logic [DW-1:0] fwd_b_data;
    logic [CW-1:0] pending;

    // clock / reset
    always #5 clk = ~clk;

    ibex_rf_wb_arbiter #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ex_we_i      (ex_we),
        .ex_waddr_i   (ex_waddr),
        .ex_wdata_i   (ex_wdata),
        .lsu_valid_i  (lsu_valid),
        .lsu_ready_o  (lsu_ready),
        .lsu_waddr_i  (lsu_waddr),
        .lsu_wdata_i  (lsu_wdata),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .raddr_a_i    (raddr_a),
        .raddr_b_i    (raddr_b),
        .fwd_a_hit_o  (fwd_a_hit),
        .fwd_b_hit_o  (fwd_b_hit),
        .fwd_a_data_o (fwd_a_data),
        .fwd_b_data_o (fwd_b_data),
        .pending_o    (pending)
    );

    // scoreboard: {addr, data} of every write the register file must see
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic ew, input logic [4:0] ea, input logic [DW-1:0] ed,
                         input logic lv, input logic [4:0] la, input logic [DW-1:0] ld);
        ex_we     = ew;
        ex_waddr  = ea;
        ex_wdata  = ed;
        lsu_valid = lv;
        lsu_waddr = la;
        lsu_wdata = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // write monitor: every rf write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_write observed=0x%0h expected=none", {rf_waddr, rf_wdata});
            end else begin
                mon_exp = exp_q.pop_front();
                check("rf_write", 64'({rf_waddr, rf_wdata}), 64'(mon_exp));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // reset state
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_ready", 64'(lsu_ready), 64'd1);
        check("rst_fwd_a_hit", 64'(fwd_a_hit), 64'd0);
        check("rst_fwd_b_hit", 64'(fwd_b_hit), 64'd0);
        check("rst_fwd_a_data", 64'(fwd_a_data), 64'd0);
        check("rst_fwd_b_data", 64'(fwd_b_data), 64'd0);
        lsu_valid = 1'b1;
        #1;
        check("rst_we_follows_valid", 64'(rf_we), 64'd1);
        lsu_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        next_cycle();

        // bypass: idle ex, empty queue
        drive(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hA5);
        expect_wr(5'd5, 32'hA5);
        @(negedge clk);
        check("byp_we", 64'(rf_we), 64'd1);
        check("byp_pending", 64'(pending), 64'd0);
        next_cycle();
        idle();
        check("byp_pending_after", 64'(pending), 64'd0);

        // collision with ex: load parked, forwarded, drained later
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        expect_wr(5'd3, 32'h11);
        @(negedge clk);
        check("col_pending_same", 64'(pending), 64'd0);
        next_cycle();
        drive(1'b1, 5'd10, 32'h33, 1'b0, 5'd0, '0);
        raddr_a = 5'd4;
        expect_wr(5'd10, 32'h33);
        @(negedge clk);
        check("col_fwd_hit", 64'(fwd_a_hit), 64'd1);
        check("col_fwd_data", 64'(fwd_a_data), 64'h22);
        check("col_pending", 64'(pending), 64'd1);
        next_cycle();
        idle();
        expect_wr(5'd4, 32'h22);
        @(negedge clk);
        check("col_drain_we", 64'(rf_we), 64'd1);
        next_cycle();
        check("col_pending_empty", 64'(pending), 64'd0);
        check("col_fwd_gone", 64'(fwd_a_hit), 64'd0);
        raddr_a = 5'd0;

        // fill to Depth, ready drops, pop reopens it
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1);
        expect_wr(5'd1, 32'h1);
        @(negedge clk);
        check("full_a_ready", 64'(lsu_ready), 64'd1);
        next_cycle();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hB2);
        expect_wr(5'd2, 32'h2);
        @(negedge clk);
        check("full_b_ready", 64'(lsu_ready), 64'd1);
        check("full_b_pending", 64'(pending), 64'd1);
        next_cycle();
        drive(1'b1, 5'd3, 32'h3, 1'b1, 5'd13, 32'hB3);
        expect_wr(5'd3, 32'h3);
        @(negedge clk);
        check("full_c_ready", 64'(lsu_ready), 64'd0);
        check("full_c_pending", 64'(pending), 64'd2);
        next_cycle();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd13, 32'hB3);
        expect_wr(5'd11, 32'hB1);
        @(negedge clk);
        check("full_d_ready", 64'(lsu_ready), 64'd0);
        check("full_d_pending", 64'(pending), 64'd2);
        next_cycle();
        expect_wr(5'd12, 32'hB2);
        @(negedge clk);
        check("full_e_ready", 64'(lsu_ready), 64'd1);
        check("full_e_pending", 64'(pending), 64'd1);
        next_cycle();
        idle();
        expect_wr(5'd13, 32'hB3);
        @(negedge clk);
        check("full_f_pending", 64'(pending), 64'd1);
        next_cycle();
        check("full_drained", 64'(pending), 64'd0);

        // youngest match wins; x0 never forwarded
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'hC1);
        expect_wr(5'd1, 32'h1);
        next_cycle();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd20, 32'hC2);
        expect_wr(5'd2, 32'h2);
        next_cycle();
        drive(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, '0);
        expect_wr(5'd3, 32'h3);
        raddr_b = 5'd20;
        raddr_a = 5'd0;
        @(negedge clk);
        check("young_b_hit", 64'(fwd_b_hit), 64'd1);
        check("young_b_data", 64'(fwd_b_data), 64'hC2);
        check("young_x0_miss", 64'(fwd_a_hit), 64'd0);
        check("young_pending", 64'(pending), 64'd2);
        next_cycle();
        idle();
        expect_wr(5'd20, 32'hC1);
        next_cycle();
        expect_wr(5'd20, 32'hC2);
        next_cycle();
        check("young_drained", 64'(pending), 64'd0);
        raddr_b = 5'd0;

        // WAW kill: parked x7 overtaken by ex x7
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h55);
        expect_wr(5'd1, 32'h1);
        next_cycle();
        drive(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, '0);
        raddr_a = 5'd7;
        expect_wr(5'd7, 32'h99);
        @(negedge clk);
        check("kill_pre_hit", 64'(fwd_a_hit), 64'd1);
        check("kill_pre_data", 64'(fwd_a_data), 64'h55);
        next_cycle();
        idle();
        @(negedge clk);
        check("kill_fwd_miss", 64'(fwd_a_hit), 64'd0);
        check("kill_fwd_data", 64'(fwd_a_data), 64'd0);
        check("kill_pending", 64'(pending), 64'd1);
        check("kill_pop_we", 64'(rf_we), 64'd0);
        next_cycle();
        check("kill_drained", 64'(pending), 64'd0);
        raddr_a = 5'd0;

        // same-cycle same-destination: load dropped
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        expect_wr(5'd9, 32'h1);
        @(negedge clk);
        check("same_ready", 64'(lsu_ready), 64'd1);
        next_cycle();
        idle();
        check("same_pending", 64'(pending), 64'd0);
        @(negedge clk);
        check("same_no_write", 64'(rf_we), 64'd0);
        next_cycle();

        // x0 load under ex is never parked
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd0, 32'hDD);
        expect_wr(5'd1, 32'h1);
        next_cycle();
        idle();
        check("x0_pending", 64'(pending), 64'd0);
        next_cycle();

        // reset mid-operation discards pending entries
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hE1);
        expect_wr(5'd1, 32'h1);
        next_cycle();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd15, 32'hE2);
        expect_wr(5'd2, 32'h2);
        next_cycle();
        check("rstm_pending_before", 64'(pending), 64'd2);
        rst_n = 1'b0;
        idle();
        raddr_a = 5'd14;
        #1;
        check("rstm_pending", 64'(pending), 64'd0);
        check("rstm_ready", 64'(lsu_ready), 64'd1);
        check("rstm_fwd", 64'(fwd_a_hit), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();
        check("rstm_pending_after", 64'(pending), 64'd0);
        raddr_a = 5'd0;

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
